// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-add cell (two half adders plus an OR)
// is reused for WIDTH cycles, LSB first, behind valid/ready command and result handshakes.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             s1, c1, s_bit, c2, c_bit;
  logic [WIDTH-1:0] res_next;

  half_adder u_ha0 (.x(a_sr[0]), .y(b_sr[0]), .s(s1),    .c(c1));
  half_adder u_ha1 (.x(s1),      .y(carry),   .s(s_bit), .c(c2));
  assign c_bit = c1 | c2;

  // res_sr only needs the upper WIDTH-1 bits; the newest bit completes the word.
  assign res_next = {s_bit, res_sr};

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      sum        <= '0;
      cout       <= 1'b0;
      done_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next[WIDTH-1:1];
          carry  <= c_bit;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            sum        <= res_next;
            cout       <= c_bit;
            done_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (done_ready) begin
            done_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
